// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, ALU_Op
// codes (also used by ALU control), sequencer states and opcode classes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [2:0] ALU_OP_R    = 3'b000;
  localparam logic [2:0] ALU_OP_I    = 3'b001;
  localparam logic [2:0] ALU_OP_LDST = 3'b010;
  localparam logic [2:0] ALU_OP_LUI  = 3'b100;
  localparam logic [2:0] ALU_OP_B    = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_WB_ALU = 3'd6,
    ST_WB_MEM = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_B       = 3'd4,
    CLS_LUI     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  // ALU_Op sent to ALU control for each instruction class.
  function automatic logic [2:0] class_alu_op(input op_class_t cls);
    logic [2:0] op;
    case (cls)
      CLS_R:         op = ALU_OP_R;
      CLS_I:         op = ALU_OP_I;
      CLS_LW, CLS_SW: op = ALU_OP_LDST;
      CLS_LUI:       op = ALU_OP_LUI;
      CLS_B:         op = ALU_OP_B;
      default:       op = ALU_OP_R;
    endcase
    return op;
  endfunction

  // Immediate feeds ALU operand B for everything except register/compare ops.
  function automatic logic class_src_b(input op_class_t cls);
    logic sel;
    case (cls)
      CLS_I, CLS_LW, CLS_SW, CLS_LUI: sel = 1'b1;
      default:                        sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classifier: IR opcode field -> instruction class and legality.
module opcode_class_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] op_class,
  output logic       legal
);

  // Map each supported opcode to its class; anything else is illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    legal    = 1'b1;
    case (opcode)
      OPC_R:   op_class = CLS_R;
      OPC_I:   op_class = CLS_I;
      OPC_LW:  op_class = CLS_LW;
      OPC_SW:  op_class = CLS_SW;
      OPC_B:   op_class = CLS_B;
      OPC_LUI: op_class = CLS_LUI;
      default: begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a ready-handshake
// memory wait and timeout. Outputs are decoded from the state register, with
// ir_write following mem_ready and pc_src following branch_taken.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  input  logic       branch_taken_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       pc_write_o,
  output logic       pc_src_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       bus_error_o
);

  localparam logic [TIMEOUT_W-1:0] WAIT_ZERO = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] WAIT_ONE  = TIMEOUT_W'(32'd1);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = {TIMEOUT_W{1'b1}};

  state_t               state_r, state_s;
  logic [TIMEOUT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic [2:0]           alu_op_hold_r;
  logic                 alu_src_b_hold_r;
  logic [2:0]           cls_raw_s;
  op_class_t            cls_s;
  logic                 legal_s;
  logic                 waiting_s;
  logic                 timeout_s;

  opcode_class_decode u_decode (
    .opcode   (opcode_i),
    .op_class (cls_raw_s),
    .legal    (legal_s)
  );

  assign cls_s     = op_class_t'(cls_raw_s);
  assign waiting_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
  assign timeout_s = waiting_s && !mem_ready_i && (wait_cnt_r == WAIT_LAST);

  // Next-state and per-state output decode; every output defaults to 0.
  always_comb begin
    state_s      = state_r;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_b_o  = 1'b0;
    alu_op_o     = 3'b000;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    bus_error_o  = 1'b0;
    case (state_r)
      ST_IDLE: state_s = ST_FETCH;
      ST_FETCH: begin
        mem_read_o = 1'b1;
        ir_write_o = mem_ready_i;
        if (mem_ready_i) begin
          state_s = ST_DECODE;
        end else if (timeout_s) begin
          // PC untouched: the same fetch is retried from a fresh wait.
          bus_error_o  = 1'b1;
          instr_done_o = 1'b1;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (legal_s) begin
          state_s = ST_EXEC;
        end else begin
          illegal_o    = 1'b1;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
          state_s      = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_op_o    = class_alu_op(cls_s);
        alu_src_b_o = class_src_b(cls_s);
        case (cls_s)
          CLS_B: begin
            pc_write_o   = 1'b1;
            pc_src_o     = branch_taken_i;
            instr_done_o = 1'b1;
            state_s      = ST_FETCH;
          end
          CLS_LW:                 state_s = ST_MEM_RD;
          CLS_SW:                 state_s = ST_MEM_WR;
          CLS_R, CLS_I, CLS_LUI:  state_s = ST_WB_ALU;
          default: begin
            // Opcode changed after DECODE: skip the instruction safely.
            pc_write_o   = 1'b1;
            instr_done_o = 1'b1;
            state_s      = ST_FETCH;
          end
        endcase
      end
      ST_MEM_RD, ST_MEM_WR: begin
        mem_read_o  = (state_r == ST_MEM_RD);
        mem_write_o = (state_r == ST_MEM_WR);
        i_or_d_o    = 1'b1;
        alu_op_o    = alu_op_hold_r;
        alu_src_b_o = alu_src_b_hold_r;
        if (mem_ready_i && (state_r == ST_MEM_RD)) begin
          state_s = ST_WB_MEM;
        end else if (mem_ready_i) begin
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
          state_s      = ST_FETCH;
        end else if (timeout_s) begin
          bus_error_o  = 1'b1;
          pc_write_o   = 1'b1;
          instr_done_o = 1'b1;
          state_s      = ST_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      ST_WB_ALU, ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (state_r == ST_WB_MEM);
        alu_op_o     = alu_op_hold_r;
        alu_src_b_o  = alu_src_b_hold_r;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        state_s      = ST_FETCH;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Wait counter: restarts on every state entry (including a fetch retry),
  // counts not-ready cycles and saturates.
  always_comb begin
    if ((state_s != state_r) || timeout_s) begin
      wait_cnt_s = WAIT_ZERO;
    end else if (waiting_s && !mem_ready_i && (wait_cnt_r != WAIT_MAX)) begin
      wait_cnt_s = wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_s = wait_cnt_r;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= WAIT_ZERO;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Capture the EXEC ALU controls so the ALU result stays stable in MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op_hold_r    <= 3'b000;
      alu_src_b_hold_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      alu_op_hold_r    <= alu_op_o;
      alu_src_b_hold_r <= alu_src_b_o;
    end
  end

endmodule
